example_02_ctrl: RTL and testbench

- Small 3-bit mode-controlled register block driven by three control strobes (A, B, C) and a 4-bit data nibble (D).
- Each clock, Q does one of the following: loads the population count of D, shifts in A serially, increments, or holds.
- Used as a simple status/count register in control-path glue logic.

---
 rtl/example_02_ctrl.sv | 49 ++++
 tb/tb_example_02_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/example_02_ctrl.sv
// 3-bit status/count register: popcount load, serial shift-in, increment or hold.
// Build option EXAMPLE_02_SAT_EN makes the increment mode saturate at 7 instead of wrapping.
module example_02_ctrl (
  input  logic       clk,
  input  logic       rstN,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic [3:0] D,
  output logic [2:0] Q
);

  logic [2:0] q_p0;
  logic [2:0] q_nxt;

  // Ones count of a nibble; the maximum of 4 always fits in 3 bits.
  function automatic logic [2:0] popcount4(input logic [3:0] d);
    return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
  endfunction

  function automatic logic [2:0] incr(input logic [2:0] q);
`ifdef EXAMPLE_02_SAT_EN
    return (q == 3'd7) ? q : q + 3'd1;
`else
    return q + 3'd1;
`endif
  endfunction

  always_comb begin
    q_nxt = q_p0;
    if (C)
      q_nxt = popcount4(D);
    else if (B)
      q_nxt = {q_p0[1:0], A};
    else if (A)
      q_nxt = incr(q_p0);
  end

  // Stage p0: the only register; rstN is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rstN)
      q_p0 <= 3'd0;
    else
      q_p0 <= q_nxt;
  end

  assign Q = q_p0;

endmodule

// File: tb/tb_example_02_ctrl.sv
// Bench for example_02_ctrl: directed steps followed by a random run against a behavioural model.
module tb_example_02_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       C = 1'b0;
  logic [3:0] D = 4'd0;
  logic [2:0] Q;

  int errors = 0;
  int checks = 0;
  int mq = 0;

  example_02_ctrl dut (
    .clk (clk),
    .rstN(rstN),
    .A   (A),
    .B   (B),
    .C   (C),
    .D   (D),
    .Q   (Q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, let the edge happen, then advance the reference value.
  task automatic step(input logic r, input logic a, input logic b, input logic c,
                      input logic [3:0] d);
    @(negedge clk);
    rstN = r; A = a; B = b; C = c; D = d;
    @(posedge clk);
    #1;
    if (r)
      mq = 0;
    else if (c)
      mq = $countones(d);
    else if (b)
      mq = (mq * 2 + int'(a)) % 8;
    else if (a) begin
`ifdef EXAMPLE_02_SAT_EN
      mq = (mq == 7) ? 7 : mq + 1;
`else
      mq = (mq + 1) % 8;
`endif
    end
  endtask

  initial begin
    logic [2:0] e;
    logic [2:0] shift_exp [4];
    logic       shift_a   [4];
    logic [3:0] pc_d      [4];
    logic [2:0] pc_exp    [4];
    shift_exp = '{3'd1, 3'd2, 3'd5, 3'd3};
    shift_a   = '{1'b1, 1'b0, 1'b1, 1'b1};
    pc_d      = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
    pc_exp    = '{3'd0, 3'd1, 3'd2, 3'd4};

    step(1, 0, 0, 0, 4'h0);
    chk("reset_initial", Q, 3'd0);

    // Bring Q to 5, then reset with every other control asserted.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 4'h0);
    chk("pre_reset_q5", Q, 3'd5);
    step(1, 1, 1, 1, 4'hF);
    chk("reset_priority", Q, 3'd0);

    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 0, 4'hA);
`ifdef EXAMPLE_02_SAT_EN
      e = (i >= 6) ? 3'd7 : 3'(i + 1);
`else
      e = 3'((i + 1) % 8);
`endif
      chk($sformatf("incr_%0d", i), Q, e);
    end

    step(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, shift_a[i], 1, 0, 4'hF);
      chk($sformatf("shift_%0d", i), Q, shift_exp[i]);
    end

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, pc_d[i]);
      chk($sformatf("popcnt_%0d", i), Q, pc_exp[i]);
    end
    step(0, 1, 1, 1, 4'b0101);
    chk("popcnt_over_ab", Q, 3'd2);

    step(0, 0, 0, 1, 4'b0111);
    chk("prio_setup_q3", Q, 3'd3);
    step(0, 1, 1, 0, 4'h0);
    chk("prio_shift_over_incr", Q, 3'd7);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 4'hF);
      chk($sformatf("hold_%0d", i), Q, 3'd7);
    end

    step(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'h0);
    chk("mid_pre_q4", Q, 3'd4);
    step(1, 1, 0, 0, 4'h0);
    chk("mid_reset", Q, 3'd0);
    step(0, 1, 0, 0, 4'h0);
    chk("mid_after_incr", Q, 3'd1);

    // Random run; reset is kept rare so longer sequences build up.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0), 4'($urandom));
      chk($sformatf("rand_%0d", i), Q, 3'(mq));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
